// File: rtl/mux_scan_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_pkg
// Shared types and constants for the registered scanning multiplexer.
//   scan_state_t : sequencer mode, STATIC (external select) or SCAN (internal)
//   DWELL_W      : width of the dwell setting and the dwell counter
// -----------------------------------------------------------------------------
package mux_scan_pkg;

    typedef enum logic {
        STATIC,
        SCAN
    } scan_state_t;

    localparam int DWELL_W = 8;

endpackage

// File: rtl/scan_seq.sv
// -----------------------------------------------------------------------------
// scan_seq
// Scan sequencer.
//
// The mode register follows `scan` one cycle late. In SCAN, the sequencer
// steps an input counter through 0..INPUTS-1 and holds each value for dwell+1
// cycles. In STATIC, the external select passes through.
//
// Ports:
//   clk, rst_b  : clock and asynchronous active-low reset
//   scan        : 0 = static mode, 1 = auto-scan mode
//   hold        : freezes both counters while high
//   dwell       : cycles per input minus one
//   s           : static select
//   sel_cur     : effective select for this cycle
//   frame_next  : this cycle is the first sample of input 0 in a frame
//   err_next    : effective select is out of range
// -----------------------------------------------------------------------------
module scan_seq
    import mux_scan_pkg::*;
#(
    parameter int INPUTS = 4,
    parameter int SW     = $clog2(INPUTS)
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               scan,
    input  logic               hold,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [SW-1:0]      s,
    output logic [SW-1:0]      sel_cur,
    output logic               frame_next,
    output logic               err_next
);

    localparam logic [SW-1:0] LAST_SEL = SW'(INPUTS - 1);

    scan_state_t        state_q, state_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [SW-1:0]      scan_cnt_q, scan_cnt_d;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= STATIC;
            dwell_cnt_q <= '0;
            scan_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            dwell_cnt_q <= dwell_cnt_d;
            scan_cnt_q  <= scan_cnt_d;
        end
    end

    // NOTE: every signal assigned here gets a default first. This keeps
    // the block purely combinational, with no inferred latch.
    always_comb begin
        state_d     = scan ? SCAN : STATIC;
        dwell_cnt_d = dwell_cnt_q;
        scan_cnt_d  = scan_cnt_q;
        if (!scan) begin
            // Leaving (or staying out of) scan: the next SCAN visit starts
            // at input 0 with a fresh dwell.
            dwell_cnt_d = '0;
            scan_cnt_d  = '0;
        end else if (state_q == SCAN && !hold) begin
            if (dwell_cnt_q == dwell) begin
                dwell_cnt_d = '0;
                scan_cnt_d  = (scan_cnt_q == LAST_SEL) ? '0 : scan_cnt_q + 1'b1;
            end else begin
                // Past a freshly lowered dwell, this wraps through 255 to 0.
                dwell_cnt_d = dwell_cnt_q + 1'b1;
            end
        end
    end

    assign sel_cur    = (state_q == SCAN) ? scan_cnt_q : s;
    assign frame_next = (state_q == SCAN) && (scan_cnt_q == '0) &&
                        (dwell_cnt_q == '0) && !hold;
    // Only the static select can reach the unused codes when INPUTS is not
    // a power of two.
    assign err_next   = (int'(sel_cur) >= INPUTS);

endmodule

// File: rtl/mux_scan_reg.sv
// -----------------------------------------------------------------------------
// mux_scan_reg
// Registered N-channel, M-to-1 multiplexer with per-channel active-low
// enables, a shared select, and an optional auto-scan sequencer.
//
// Ports:
//   clk, rst_b : clock and asynchronous active-low reset
//   i          : data inputs, [CHANNELS][INPUTS][WIDTH]
//   en_b       : per-channel active-low enable. A disabled channel outputs 0.
//   s          : static select
//   scan       : 0 = static mode, 1 = auto-scan mode
//   hold       : freezes the scan sequencer
//   dwell      : cycles per input in scan mode, minus one
//   z          : registered selected data, [CHANNELS][WIDTH]
//   sel_o      : select value that produced the current z
//   frame_o    : first sample of input 0 in a scan frame
//   err_o      : the select that produced z was >= INPUTS (z forced to 0)
// -----------------------------------------------------------------------------
module mux_scan_reg
    import mux_scan_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int INPUTS   = 4,
    parameter int CHANNELS = 2,
    parameter int SW       = $clog2(INPUTS)
) (
    input  logic                                  clk,
    input  logic                                  rst_b,
    input  logic [CHANNELS-1:0][INPUTS-1:0][WIDTH-1:0] i,
    input  logic [CHANNELS-1:0]                   en_b,
    input  logic [SW-1:0]                         s,
    input  logic                                  scan,
    input  logic                                  hold,
    input  logic [DWELL_W-1:0]                    dwell,
    output logic [CHANNELS-1:0][WIDTH-1:0]        z,
    output logic [SW-1:0]                         sel_o,
    output logic                                  frame_o,
    output logic                                  err_o
);

    logic [SW-1:0] sel_cur;
    logic          frame_next;
    logic          err_next;

    scan_seq #(
        .INPUTS (INPUTS),
        .SW     (SW)
    ) u_seq (
        .clk        (clk),
        .rst_b      (rst_b),
        .scan       (scan),
        .hold       (hold),
        .dwell      (dwell),
        .s          (s),
        .sel_cur    (sel_cur),
        .frame_next (frame_next),
        .err_next   (err_next)
    );

    logic [CHANNELS-1:0][WIDTH-1:0] z_d, z_q;
    logic [SW-1:0]                  sel_q;
    logic                           frame_q, err_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [WIDTH-1:0] pick;

        // An explicit compare loop keeps out-of-range selects from indexing
        // past the input array. The error case is zeroed anyway.
        always_comb begin
            pick = '0;
            if (!en_b[c] && !err_next) begin
                for (int k = 0; k < INPUTS; k++) begin
                    if (sel_cur == SW'(k)) begin
                        pick = i[c][k];
                    end
                end
            end
        end

        assign z_d[c] = pick;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            z_q     <= '0;
            sel_q   <= '0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            z_q     <= z_d;
            sel_q   <= sel_cur;
            frame_q <= frame_next;
            err_q   <= err_next;
        end
    end

    assign z       = z_q;
    assign sel_o   = sel_q;
    assign frame_o = frame_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_reg
// Two instances share all control inputs:
//   a: INPUTS=4, WIDTH=8
//   b: INPUTS=3, WIDTH=8 (so select 3 is out of range)
// Each negedge compares both instances against a behavioural model. Directed
// phases add literal expectations taken from the documented behaviour. A
// randomized phase follows.
// -----------------------------------------------------------------------------
module tb_mux_scan_reg;

    logic                 clk = 1'b0;
    logic                 rst_b;
    logic [1:0][3:0][7:0] i_a;
    logic [1:0][2:0][7:0] i_b;
    logic [1:0]           en_b;
    logic [1:0]           s;
    logic                 scan, hold;
    logic [7:0]           dwell;

    logic [1:0][7:0]      z_a, z_b;
    logic [1:0]           sel_a, sel_b;
    logic                 frame_a, frame_b, err_a, err_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_scan_reg #(.WIDTH(8), .INPUTS(4), .CHANNELS(2)) dut_a (
        .clk(clk), .rst_b(rst_b), .i(i_a), .en_b(en_b), .s(s), .scan(scan),
        .hold(hold), .dwell(dwell), .z(z_a), .sel_o(sel_a), .frame_o(frame_a),
        .err_o(err_a)
    );

    mux_scan_reg #(.WIDTH(8), .INPUTS(3), .CHANNELS(2)) dut_b (
        .clk(clk), .rst_b(rst_b), .i(i_b), .en_b(en_b), .s(s), .scan(scan),
        .hold(hold), .dwell(dwell), .z(z_b), .sel_o(sel_b), .frame_o(frame_b),
        .err_o(err_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- behavioural model ----------------
    int         n_in [2] = '{4, 3};
    bit         m_scanning [2];   // mode as seen one cycle after `scan`
    int         m_pos [2];        // input currently being scanned
    int         m_tick [2];       // cycles already spent on that input
    logic [7:0] e_z [2][2];
    int         e_sel [2];
    bit         e_frame [2];
    bit         e_err [2];

    always @(posedge clk or negedge rst_b) begin
        int sel;
        if (!rst_b) begin
            for (int d = 0; d < 2; d++) begin
                m_scanning[d] = 0; m_pos[d] = 0; m_tick[d] = 0;
                e_sel[d] = 0; e_frame[d] = 0; e_err[d] = 0;
                e_z[d][0] = '0; e_z[d][1] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                sel = m_scanning[d] ? m_pos[d] : int'(s);
                e_sel[d]   = sel;
                e_err[d]   = (sel >= n_in[d]);
                e_frame[d] = m_scanning[d] && m_pos[d] == 0 && m_tick[d] == 0 && !hold;
                for (int c = 0; c < 2; c++) begin
                    if (en_b[c] || e_err[d])  e_z[d][c] = 8'h00;
                    else if (d == 0)          e_z[d][c] = i_a[c][sel];
                    else                      e_z[d][c] = i_b[c][sel];
                end
                if (!scan) begin
                    m_pos[d] = 0;
                    m_tick[d] = 0;
                end else if (m_scanning[d] && !hold) begin
                    if (m_tick[d] == int'(dwell)) begin
                        m_tick[d] = 0;
                        m_pos[d]  = (m_pos[d] + 1) % n_in[d];
                    end else begin
                        m_tick[d] = (m_tick[d] + 1) % 256;
                    end
                end
                m_scanning[d] = scan;
            end
        end
    end

    bit cmp_en = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("a_z0",    32'(z_a[0]),  32'(e_z[0][0]));
            check("a_z1",    32'(z_a[1]),  32'(e_z[0][1]));
            check("a_sel",   32'(sel_a),   e_sel[0]);
            check("a_frame", 32'(frame_a), 32'(e_frame[0]));
            check("a_err",   32'(err_a),   32'(e_err[0]));
            check("b_z0",    32'(z_b[0]),  32'(e_z[1][0]));
            check("b_z1",    32'(z_b[1]),  32'(e_z[1][1]));
            check("b_sel",   32'(sel_b),   e_sel[1]);
            check("b_frame", 32'(frame_b), 32'(e_frame[1]));
            check("b_err",   32'(err_b),   32'(e_err[1]));
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_za"}, 32'(z_a), 0);
        check({tag, "_zb"}, 32'(z_b), 0);
        check({tag, "_sela"}, 32'(sel_a), 0);
        check({tag, "_selb"}, 32'(sel_b), 0);
        check({tag, "_flags"}, 32'({frame_a, frame_b, err_a, err_b}), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_b = 1'b1;
        i_a = '0; i_b = '0; en_b = '0; s = '0;
        scan = 1'b0; hold = 1'b0; dwell = '0;
        #2 rst_b = 1'b0;
        #1 check_all_zero("reset");

        // Static select
        i_a[0] = {8'h44, 8'h33, 8'h22, 8'h11};
        i_a[1] = {8'hA4, 8'hA3, 8'hA2, 8'hA1};
        i_b[0] = {8'h5C, 8'h5B, 8'h5A};
        i_b[1] = {8'h6C, 8'h6B, 8'h6A};
        s = 2'd2; en_b = 2'b10;
        step(1);
        cmp_en = 1;
        rst_b = 1'b1;
        step(1);
        check("static_z0",   32'(z_a[0]), 32'h33);
        check("static_dis",  32'(z_a[1]), 32'h00);
        check("static_sel",  32'(sel_a),  2);
        check("static_b_z0", 32'(z_b[0]), 32'h5C);
        s = 2'd3;
        step(1);
        check("oor_err_b",   32'(err_b),  1);
        check("oor_z_b",     32'(z_b[0]), 0);
        check("oor_sel_b",   32'(sel_b),  3);
        check("in4_z_a",     32'(z_a[0]), 32'h44);
        check("in4_err_a",   32'(err_a),  0);

        // Scan with dwell=2
        en_b = 2'b00; dwell = 8'd2; scan = 1'b1;
        step(1);
        for (int k = 0; k < 24; k++) begin
            step(1);
            check("scan_sel_a",   32'(sel_a),   32'((k / 3) % 4));
            check("scan_frame_a", 32'(frame_a), 32'(k % 12 == 0));
            check("scan_sel_b",   32'(sel_b),   32'((k / 3) % 3));
            check("scan_frame_b", 32'(frame_b), 32'(k % 9 == 0));
        end

        // Non-power-of-two INPUTS, dwell=0
        scan = 1'b0; step(1);
        dwell = 8'd0; scan = 1'b1; step(1);
        for (int k = 0; k < 6; k++) begin
            step(1);
            check("d0_sel_b",   32'(sel_b),   32'(k % 3));
            check("d0_frame_b", 32'(frame_b), 32'(k % 3 == 0));
        end
        scan = 1'b0; step(2);
        check("static3_err_b", 32'(err_b), 1);
        check("static3_z_b",   32'(z_b),   0);

        // Hold at scan_cnt=1 with dwell=2
        dwell = 8'd2; scan = 1'b1; step(1);
        step(4);
        check("pre_hold_sel", 32'(sel_a), 1);
        hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1);
            check("hold_sel",   32'(sel_a),   1);
            check("hold_frame", 32'(frame_a), 0);
        end
        hold = 1'b0;
        step(1); check("post_hold_sel0", 32'(sel_a), 1);
        step(1); check("post_hold_sel1", 32'(sel_a), 1);
        step(1); check("post_hold_sel2", 32'(sel_a), 2);

        // Asynchronous reset mid-frame
        rst_b = 1'b0;
        #1 check_all_zero("async_rst");
        step(2);
        rst_b = 1'b1;
        step(1);
        step(1);
        check("rst_resume_sel_a",   32'(sel_a),   0);
        check("rst_resume_frame_a", 32'(frame_a), 1);
        check("rst_resume_frame_b", 32'(frame_b), 1);

        // Scan -> static with s=3, then re-enter scan
        s = 2'd3; scan = 1'b0;
        step(2);
        check("to_static_sel", 32'(sel_a),  3);
        check("to_static_z0",  32'(z_a[0]), 32'h44);
        check("to_static_z1",  32'(z_a[1]), 32'hA4);
        scan = 1'b1;
        step(2);
        check("rescan_sel",   32'(sel_a),   0);
        check("rescan_frame", 32'(frame_a), 1);

        // One-cycle SCAN visit
        scan = 1'b0; step(1);
        scan = 1'b1; step(1);
        scan = 1'b0; step(1);
        check("blip_sel",   32'(sel_a),   0);
        check("blip_frame", 32'(frame_a), 1);
        step(1);
        check("blip_after", 32'(sel_a),   3);

        // Randomized phase against the model
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < 4; k++) i_a[c][k] = 8'($urandom);
                for (int k = 0; k < 3; k++) i_b[c][k] = 8'($urandom);
            end
            en_b = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            s    = 2'($urandom);
            if ($urandom_range(0, 39) == 0) scan = ~scan;
            hold = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 59) == 0)
                dwell = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) begin
                rst_b = 1'b0;
                step(1);
                rst_b = 1'b1;
            end
            step(1);
        end

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_scan_reg.md
# mux_scan_reg

Parametrised, registered N-channel M-to-1 multiplexer: the successor to the dual 4-input TTL selector in our logic library. It keeps the per-channel active-low enable and the shared select, and adds a registered output, a generic channel/input/width count, and an auto-scan mode. In auto-scan mode an internal sequencer steps the shared select through all inputs with a programmable dwell. It sits between multiplexed sources (button matrices, display column drivers, status banks) and synchronous consumers.

## Interface
- `WIDTH`, 1: bits per input.
- `INPUTS`, 4: inputs per channel. Range 2–16; need not be a power of two.
- `CHANNELS`, 2: independent channels sharing one select.
- `SW`, `$clog2(INPUTS)`: select width. Derived; do not override.
- `clk` in 1: sole clock, rising edge.
- `rst_b` in 1: asynchronous assert, active-low reset.
- `i` in `[CHANNELS][INPUTS][WIDTH]`: data inputs.
- `en_b` in `[CHANNELS]`: per-channel active-low enable.
- `s` in `SW`: static select, used in static mode.
- `scan` in 1: 0 = static mode, 1 = auto-scan mode.
- `hold` in 1: freezes the scan sequencer when 1.
- `dwell` in 8: cycles per input in scan mode, minus one. 0 means advance every cycle.
- `z` out `[CHANNELS][WIDTH]`: registered selected data.
- `sel_o` out `SW`: select value that produced the current `z`.
- `frame_o` out 1: one-cycle pulse aligned with `z`, marking the first sample of input 0 in a scan frame.
- `err_o` out 1: aligned with `z`; high when the select was ≥ `INPUTS`.

## Operation
- Sequencer states: `STATIC` and `SCAN`. The state register follows `scan` with one cycle of delay.
- `STATIC` → `SCAN` when `scan` = 1. The first cycle in `SCAN` uses `scan_cnt` = 0 and `dwell_cnt` = 0.
- `SCAN` → `STATIC` when `scan` = 0. The counters clear, and the next selection uses `s`.
- Effective select `sel_cur` = `s` in `STATIC`, `scan_cnt` in `SCAN`.
- `dwell_cnt` increments each cycle in `SCAN` while `hold` = 0.
- When `dwell_cnt` == `dwell` (and `hold` = 0):
  - `dwell_cnt` → 0;
  - `scan_cnt` increments, wrapping from `INPUTS`−1 to 0.
- `hold` = 1 freezes both counters. Output registers keep sampling `i[sel_cur]` every cycle.
- A change to `dwell` takes effect on the next compare. If `dwell_cnt` > new `dwell`, the count continues to 255, wraps to 0, then compares normally.
- Per channel c, each cycle: `z[c]` ← `i[c][sel_cur]` if `en_b[c]` = 0, else 0. Disabled channels output low, matching the TTL part.
- `sel_cur` ≥ `INPUTS` (static mode only): all `z` ← 0 and `err_o` ← 1.
- `frame_o` ← 1 when the state is `SCAN`, `scan_cnt` = 0, `dwell_cnt` = 0 and `hold` = 0.

## Timing
- Latency is one cycle: `z`, `sel_o`, `frame_o` and `err_o` at edge n+1 reflect inputs and state at edge n.
- Throughput is one sample per cycle. There is no handshake; consumers qualify samples with `sel_o`/`frame_o`.
- Scan frame period = `INPUTS` × (`dwell`+1) cycles, with `hold` = 0.
- Reset values (`rst_b` low, asynchronous):
  - state `STATIC`, `scan_cnt` 0, `dwell_cnt` 0;
  - `z` all 0, `sel_o` 0, `frame_o` 0, `err_o` 0.
- Deassertion of `rst_b` is synchronised externally. The first active edge after release samples normally.
- Reset mid-scan abandons the frame. After release, scanning (if `scan` = 1) resumes one cycle later at input 0 with a `frame_o` pulse.
- Simultaneous `hold` rise and wrap: `hold` wins. No increment and no `frame_o`.
- `scan` toggled on consecutive cycles: each toggle is honoured. A one-cycle `SCAN` visit outputs input 0 once, with `frame_o`.

## Structure
- Package `mux_scan_pkg` holds:
  - `typedef enum logic {STATIC, SCAN} scan_state_t`;
  - `localparam int DWELL_W = 8`.
- Sub-module `scan_seq` holds the state register, `dwell_cnt` and `scan_cnt`, and outputs `sel_cur`, `frame_next` and `err_next`.
- The top level holds a per-channel generate loop of select/enable logic plus the output registers.

## Test plan
- Static select, `INPUTS`=4, `WIDTH`=8, `i[0]` = {0x11, 0x22, 0x33, 0x44}, `s`=2, `en_b`=0 → one cycle later `z[0]`=0x33 and `sel_o`=2. With `en_b[1]`=1, `z[1]`=0.
- Scan with `dwell`=2, `INPUTS`=4 → `sel_o` sequence is 0,0,0,1,1,1,2,2,2,3,3,3,0…, and `frame_o` pulses every 12 cycles.
- Non-power-of-two `INPUTS`=3, `dwell`=0 → `sel_o` is 0,1,2,0. Static `s`=3 → `z`=0 and `err_o`=1.
- Assert `hold` for 5 cycles at `scan_cnt`=1 → `sel_o` stays 1 for the whole hold, plus the remaining dwell, then resumes at 2. No `frame_o` during the hold.
- Assert `rst_b`=0 mid-frame at `scan_cnt`=2 → all outputs are 0 immediately (asynchronously). After release with `scan`=1, `sel_o`=0 and `frame_o`=1 on the second edge.
- Switch mode 1→0 with `s`=3 → the next `z` reflects input 3, and re-entering scan restarts at input 0.
